// File: rtl/kypd_emu_pkg.sv
// kypd_pkg: shared definitions for the Pmod KYPD emulator and its decoder.
//   - KEY_MAP: key index at (column c, row r), nibble index c*4 + r.
//   - key_at / key_col / key_row: lookups in both directions.
//   - kypd_state_t: sequencer FSM states.
package kypd_pkg;

    // Nibble (c*4 + r) holds the key at column c, row r.
    //   col0: 1 4 7 0   col1: 2 5 8 F   col2: 3 6 9 E   col3: A B C D
    localparam logic [63:0] KEY_MAP = 64'hDCBA_E963_F852_0741;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } kypd_state_t;

    function automatic logic [3:0] key_at(input int unsigned c, input int unsigned r);
        return KEY_MAP[(c * 4 + r) * 4 +: 4];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] k);
        logic [1:0] res;
        res = 2'd0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (key_at(c, r) == k) res = 2'(c);
        return res;
    endfunction

    function automatic logic [1:0] key_row(input logic [3:0] k);
        logic [1:0] res;
        res = 2'd0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (key_at(c, r) == k) res = 2'(r);
        return res;
    endfunction

endpackage

// File: rtl/kypd_emu_if.sv
// kypd_emu_if: key injection queue handshake.
//   key_code  : key to queue, 0x0..0xF
//   key_valid : push request
//   key_ready : queue can accept this cycle
// Handshake: a key is transferred on a rising clk edge exactly when
// key_valid && key_ready are both high; key_code must be stable while
// key_valid is high, and key_ready may drop without a transfer.
interface kypd_emu_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_code, output key_valid, input  key_ready);
    modport slave  (input  key_code, input  key_valid, output key_ready);
endinterface

// File: rtl/kypd_emu_fifo.sv
// kypd_emu_fifo: synchronous FIFO with occupancy count and flush.
//   clk, rst : clock, asynchronous active-high reset
//   flush    : empties the queue; wins over push/pop in the same cycle
//   push/din : write, ignored when full
//   pop/dout : read, dout shows the head entry combinationally
//   count    : registered occupancy, 0..DEPTH
module kypd_emu_fifo #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok, pop_ok;

    assign push_ok = push && !flush && (count_q != FULL);
    assign pop_ok  = pop  && !flush && (count_q != '0);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

    // Pointers are power-of-two wide, so the +1 wraps modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/kypd_emu.sv
// kypd_emu: Pmod KYPD keypad emulator (keypad side of a 4x4 column scan).
//   clk, rst   : clock, asynchronous active-high reset
//   col        : active-low column lines from the scanner (async to clk)
//   row        : active-low row lines back to the scanner, registered
//   key_if     : queued key injection (valid/ready)
//   force_keys : static pressed mask, bit n = key n
//   clear      : synchronous flush of queue and sequencer
//   pressed    : registered effective pressed mask
//   busy       : queue non-empty or sequencer active, registered
//   dbg_state  : sequencer FSM state
module kypd_emu
    import kypd_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 524288,
    parameter int unsigned GAP_CYCLES  = 524288,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    kypd_emu_if.slave   key_if,
    input  logic [15:0] force_keys,
    input  logic        clear,
    output logic [15:0] pressed,
    output logic        busy,
    output kypd_state_t dbg_state
);
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FCNT_W-1:0] FULL = FCNT_W'(FIFO_DEPTH);

    logic [3:0]        col_s1_q, col_s_q;
    logic [3:0]        row_q, row_d;
    logic [15:0]       pressed_q, pressed_d;
    logic              busy_q, busy_d;
    kypd_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        cur_key_q, cur_key_d;
    logic [15:0]       seq_mask;
    logic              push, pop;
    logic [3:0]        fifo_dout;
    logic [FCNT_W-1:0] fifo_count, fifo_count_nx;
    logic              key_ready;

    // Ready looks only at the registered count, so a pop never frees a
    // slot for a push in the same cycle.
    assign key_ready        = (fifo_count != FULL) && !clear;
    assign key_if.key_ready = key_ready;
    assign push             = key_if.key_valid && key_ready;

    kypd_emu_fifo #(
        .W     (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clear),
        .push  (push),
        .din   (key_if.key_code),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_key_d = cur_key_q;
        pop       = 1'b0;
        seq_mask  = '0;
        case (state_q)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    cur_key_d = fifo_dout;
                    cnt_d     = CNT_W'(HOLD_CYCLES - 1);
                    state_d   = PRESS;
                end
            end
            PRESS: begin
                seq_mask = 16'd1 << cur_key_q;
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // clear drops the key in flight so pressed is already 0 on the next edge.
        if (clear) begin
            state_d  = IDLE;
            cnt_d    = '0;
            pop      = 1'b0;
            seq_mask = '0;
        end
    end

    // Queue occupancy after this edge, so busy can be registered in step
    // with the FSM.
    always_comb begin
        fifo_count_nx = fifo_count;
        if (clear) begin
            fifo_count_nx = '0;
        end else begin
            if (push) fifo_count_nx = fifo_count_nx + 1'b1;
            if (pop)  fifo_count_nx = fifo_count_nx - 1'b1;
        end
    end

    assign busy_d    = (state_d != IDLE) || (fifo_count_nx != '0);
    assign pressed_d = seq_mask | force_keys;

    // Several low columns AND onto the rows, as on the real wired matrix.
    always_comb begin
        row_d = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col_s_q[c] && pressed_q[key_at(c, r)]) row_d[r] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_s1_q  <= 4'hF;
            col_s_q   <= 4'hF;
            row_q     <= 4'hF;
            pressed_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_key_q <= '0;
        end else begin
            col_s1_q  <= col;
            col_s_q   <= col_s1_q;
            row_q     <= row_d;
            pressed_q <= pressed_d;
            busy_q    <= busy_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_key_q <= cur_key_d;
        end
    end

    assign row       = row_q;
    assign pressed   = pressed_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_kypd_emu.sv
module tb_kypd_emu;
    import kypd_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] force_keys;
    logic        clear;
    logic [15:0] pressed;
    logic        busy;
    kypd_state_t dbg_state;

    int total = 0;
    int bad   = 0;

    kypd_emu_if kif();

    always #5 clk = ~clk;

    kypd_emu #(
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (3),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .col        (col),
        .row        (row),
        .key_if     (kif),
        .force_keys (force_keys),
        .clear      (clear),
        .pressed    (pressed),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_p;
        logic        exp_b;

        // ---------------- reset ----------------
        rst = 1'b1; col = 4'hF; force_keys = '0; clear = 1'b0;
        kif.key_valid = 1'b0; kif.key_code = 4'h0;
        step(3);
        chk("rst_row",     32'(row),       32'hF);
        chk("rst_pressed", 32'(pressed),   32'h0);
        chk("rst_busy",    32'(busy),      32'd0);
        chk("rst_state",   32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        col = 4'b1110;
        step(4);
        chk("idle_row",   32'(row),           32'hF);
        chk("idle_ready", 32'(kif.key_ready), 32'd1);
        chk("idle_busy",  32'(busy),          32'd0);

        // ---------------- force mask and row drive ----------------
        force_keys = 16'h0080;                      // key 7: col0,row2
        step(1);
        chk("force_pressed", 32'(pressed), 32'h0080);
        chk("force_row_lag", 32'(row),     32'hF);
        step(1);
        chk("force_row",     32'(row),     32'b1011);
        col = 4'b1101;
        step(2);
        chk("col_lat2_hold", 32'(row), 32'b1011);
        step(1);
        chk("col_lat3_rel",  32'(row), 32'hF);
        col = 4'b1110;
        step(2);
        chk("col_lat2_low",  32'(row), 32'hF);
        step(1);
        chk("col_lat3_low",  32'(row), 32'b1011);
        force_keys = 16'h00A0;                      // keys 7 and 5 (col1,row1)
        col = 4'b1100;
        step(3);
        chk("multi_col_row", 32'(row), 32'b1001);
        force_keys = '0;
        col = 4'b1111;
        step(3);
        chk("force_off_pressed", 32'(pressed), 32'h0);
        chk("force_off_row",     32'(row),     32'hF);

        // ---------------- queued sequence 0x5 then 0xF ----------------
        kif.key_code = 4'h5; kif.key_valid = 1'b1;
        for (int j = 1; j <= 18; j++) begin
            step(1);
            if (j == 1) kif.key_code  = 4'hF;
            if (j == 2) kif.key_valid = 1'b0;
            exp_p = (j >= 3 && j <= 6)   ? 16'h0020 :
                    (j >= 11 && j <= 14) ? 16'h8000 : 16'h0000;
            exp_b = (j <= 16);
            chk($sformatf("seq_pressed_%0d", j), 32'(pressed), 32'(exp_p));
            chk($sformatf("seq_busy_%0d", j),    32'(busy),    32'(exp_b));
            if (j == 2) chk("seq_state_press", 32'(dbg_state), 32'(PRESS));
            if (j == 6) chk("seq_state_gap",   32'(dbg_state), 32'(GAP));
            if (j == 9) chk("seq_state_idle",  32'(dbg_state), 32'(IDLE));
        end

        // ---------------- fill the queue, pop-cycle push rejected ----------------
        kif.key_code = 4'hA; kif.key_valid = 1'b1;
        for (int j = 1; j <= 45; j++) begin
            step(1);
            if (j <= 4)           chk($sformatf("full_ready_%0d", j), 32'(kif.key_ready), 32'd1);
            if (j >= 5 && j <= 9) chk($sformatf("full_ready_%0d", j), 32'(kif.key_ready), 32'd0);
            if (j == 10) chk("full_ready_after_pop", 32'(kif.key_ready), 32'd1);
            if (j == 9)  chk("full_pop_state",       32'(dbg_state),     32'(IDLE));
            if (j == 11) chk("full_key1",  32'(pressed), 32'h0002);
            if (j == 19) chk("full_key2",  32'(pressed), 32'h0004);
            if (j == 27) chk("full_key3",  32'(pressed), 32'h0008);
            if (j == 35) chk("full_key4",  32'(pressed), 32'h0010);
            if (j == 40) chk("full_busy_last_gap", 32'(busy), 32'd1);
            if (j == 41) chk("full_busy_done",     32'(busy), 32'd0);
            if (j == 45) chk("full_no_extra_key",  32'(pressed), 32'h0);
            case (j)
                1: kif.key_code = 4'h1;
                2: kif.key_code = 4'h2;
                3: kif.key_code = 4'h3;
                4: kif.key_code = 4'h4;
                5: kif.key_code = 4'h7;
                9: kif.key_valid = 1'b0;
                default: ;
            endcase
        end

        // ---------------- clear during PRESS ----------------
        force_keys = 16'h0001;                      // key 0 stays forced through clear
        col = 4'b0111;                              // scan column 3 (A B C D)
        step(3);
        kif.key_code = 4'hB; kif.key_valid = 1'b1;
        step(1);
        kif.key_code = 4'hC;
        step(1);
        kif.key_code = 4'hD;
        step(1);
        chk("clr_pre_pressed", 32'(pressed),   32'h0801);
        chk("clr_pre_state",   32'(dbg_state), 32'(PRESS));
        clear = 1'b1; kif.key_code = 4'hE;
        #1;
        chk("clr_ready_low", 32'(kif.key_ready), 32'd0);
        step(1);
        chk("clr_pressed",  32'(pressed),   32'h0001);
        chk("clr_busy",     32'(busy),      32'd0);
        chk("clr_state",    32'(dbg_state), 32'(IDLE));
        chk("clr_row_last", 32'(row),       32'b1101);
        clear = 1'b0; kif.key_valid = 1'b0;
        #1;
        chk("clr_ready_back", 32'(kif.key_ready), 32'd1);
        step(1);
        chk("clr_row_rel", 32'(row), 32'hF);
        step(12);
        chk("clr_post_pressed", 32'(pressed), 32'h0001);
        chk("clr_post_busy",    32'(busy),    32'd0);

        // ---------------- reset mid-sequence ----------------
        force_keys = '0;
        col = 4'b1110;                              // scan column 0
        kif.key_code = 4'h4; kif.key_valid = 1'b1;  // key 4: col0,row1
        step(1);
        kif.key_code = 4'h9;
        step(1);
        kif.key_valid = 1'b0;
        step(2);
        chk("mid_pressed", 32'(pressed), 32'h0010);
        chk("mid_row",     32'(row),     32'b1101);
        rst = 1'b1;
        #1;
        chk("arst_row",     32'(row),       32'hF);
        chk("arst_pressed", 32'(pressed),   32'h0);
        chk("arst_busy",    32'(busy),      32'd0);
        chk("arst_state",   32'(dbg_state), 32'(IDLE));
        step(2);
        rst = 1'b0;
        step(12);
        chk("post_rst_pressed", 32'(pressed),       32'h0);
        chk("post_rst_busy",    32'(busy),          32'd0);
        chk("post_rst_ready",   32'(kif.key_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
